// File: rtl/pcie_scr_pkg.sv
// Shared constants and state type for the PCIe Gen1/2 byte scrambler sequencer.
package pcie_scr_pkg;
  localparam int LFSR_W = 16;
  localparam logic [7:0] COM_SYM = 8'hBC;
  localparam logic [7:0] SKP_SYM = 8'h1C;
  localparam logic [LFSR_W-1:0] LFSR_SEED_DEF = 16'hFFFF;

  typedef enum logic [1:0] {OFF, HUNT, LOCK} scr_state_e;
endpackage

// File: rtl/pcie_lfsr_byte_step.sv
// Eight serial steps of the x^16+x^5+x^4+x^3+1 scrambler LFSR, unrolled combinationally.
module pcie_lfsr_byte_step
  import pcie_scr_pkg::*;
(
  input  logic [LFSR_W-1:0] lfsr_i,
  output logic [7:0]        ks_o,
  output logic [LFSR_W-1:0] lfsr_o
);
  always_comb begin
    logic [LFSR_W-1:0] l;
    l    = lfsr_i;
    ks_o = '0;
    // Keystream bit i is taken before step i; bit 0 scrambles data bit 0.
    for (int i = 0; i < 8; i++) begin
      ks_o[i] = l[15];
      l = {l[14:5], l[4] ^ l[15], l[3] ^ l[15], l[2] ^ l[15], l[1], l[0], l[15]};
    end
    lfsr_o = l;
  end
endmodule

// File: rtl/pcie_scrambler_ctrl.sv
// Per-symbol scrambler sequencer: COM-based lock, SKP hold, TS/K advance, D scramble.
module pcie_scrambler_ctrl
  import pcie_scr_pkg::*;
#(
  parameter logic [LFSR_W-1:0] LFSR_SEED = LFSR_SEED_DEF,
  parameter int                CNT_W     = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              scr_en_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [7:0]        in_data_i,
  input  logic              in_k_i,
  input  logic              in_ts_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [7:0]        out_data_o,
  output logic              out_k_o,
  output logic              synced_o,
  output logic [LFSR_W-1:0] lfsr_o,
  output logic [CNT_W-1:0]  scr_cnt_o
);
  scr_state_e        state_q, state_d;
  logic [LFSR_W-1:0] lfsr_q, lfsr_d, lfsr_adv;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ov_q, ok_q;
  logic [7:0]        od_q, od_d, ks;
  logic              acc, is_com, is_skp;

  pcie_lfsr_byte_step u_step (
    .lfsr_i (lfsr_q),
    .ks_o   (ks),
    .lfsr_o (lfsr_adv)
  );

  assign in_ready_o = !rst_i && (!ov_q || out_ready_i);
  assign acc        = in_valid_i && in_ready_o;
  assign is_com     = in_k_i && (in_data_i == COM_SYM);
  assign is_skp     = in_k_i && (in_data_i == SKP_SYM);

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    cnt_d   = cnt_q;
    od_d    = in_data_i;
    if (acc && is_com) cnt_d = '0;
    unique case (state_q)
      OFF: begin
        lfsr_d = LFSR_SEED;
        if (scr_en_i) state_d = HUNT;
      end
      HUNT: begin
        lfsr_d = LFSR_SEED;
        if (!scr_en_i)         state_d = OFF;
        else if (acc && is_com) state_d = LOCK;
      end
      LOCK: begin
        if (acc) begin
          if (is_com) begin
            lfsr_d = LFSR_SEED;
            // A training-driven disable is only honoured on a COM boundary.
            if (!scr_en_i) state_d = OFF;
          end else if (!is_skp) begin
            lfsr_d = lfsr_adv;
            if (!in_k_i && !in_ts_i) begin
              od_d = in_data_i ^ ks;
              if (cnt_q != '1) cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
          end
        end
      end
      default: state_d = OFF;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= OFF;
      lfsr_q  <= LFSR_SEED;
      cnt_q   <= '0;
      ov_q    <= 1'b0;
      od_q    <= '0;
      ok_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      cnt_q   <= cnt_d;
      if (acc) begin
        ov_q <= 1'b1;
        od_q <= od_d;
        ok_q <= in_k_i;
      end else if (out_ready_i) begin
        ov_q <= 1'b0;
      end
    end
  end

  assign out_valid_o = ov_q;
  assign out_data_o  = od_q;
  assign out_k_o     = ok_q;
  assign synced_o    = (state_q == LOCK);
  assign lfsr_o      = lfsr_q;
  assign scr_cnt_o   = cnt_q;
endmodule

// File: tb/tb_pcie_scrambler_ctrl.sv
// Bench for pcie_scrambler_ctrl: cycle model of the symbol rules plus fixed test-plan vectors.
module tb_pcie_scrambler_ctrl;
  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1, scr_en_i = 1'b0, in_valid_i = 1'b0, in_k_i = 1'b0, in_ts_i = 1'b0;
  logic        out_ready_i = 1'b1;
  logic [7:0]  in_data_i = 8'h00;
  logic        in_ready_o, out_valid_o, out_k_o, synced_o;
  logic [7:0]  out_data_o;
  logic [15:0] lfsr_o, scr_cnt_o;

  pcie_scrambler_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i), .scr_en_i(scr_en_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i),
    .in_k_i(in_k_i), .in_ts_i(in_ts_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
    .out_k_o(out_k_o), .synced_o(synced_o), .lfsr_o(lfsr_o), .scr_cnt_o(scr_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int n_chk = 0, n_fail = 0;

  // Model: 0 = off, 1 = hunting for COM, 2 = locked
  int          m_st  = 0;
  logic [15:0] m_l   = 16'hFFFF;
  logic [15:0] m_cnt = 16'h0;
  bit          m_ov  = 1'b0;
  logic [7:0]  m_od  = 8'h00;
  bit          m_ok  = 1'b0;
  logic [7:0]  outs[$];

  // Galois-form view of the polynomial: shift left, fold x^16 back as 0x0039.
  function automatic logic [23:0] scr_byte(input logic [15:0] l);
    logic [7:0] k;
    for (int i = 0; i < 8; i++) begin
      k[i] = l[15];
      l = (l << 1) ^ (l[15] ? 16'h0039 : 16'h0000);
    end
    return {k, l};
  endfunction

  task automatic tick();
    bit rdy, acc, com, skp;
    int ns;
    logic [15:0] nl, ncnt;
    logic [23:0] r;
    #1;
    rdy = !rst_i && (!m_ov || out_ready_i);
    n_chk++;
    if (in_ready_o !== rdy) begin
      n_fail++; $display("FAIL in_ready: got %b want %b at %0t", in_ready_o, rdy, $time);
    end
    acc = in_valid_i && rdy;
    com = in_k_i && (in_data_i == 8'hBC);
    skp = in_k_i && (in_data_i == 8'h1C);
    r = scr_byte(m_l);
    if (rst_i) begin
      m_st = 0; m_l = 16'hFFFF; m_cnt = 0; m_ov = 0; m_od = 0; m_ok = 0;
    end else begin
      ns = m_st; nl = m_l; ncnt = m_cnt;
      if (acc) begin m_od = in_data_i; m_ok = in_k_i; end
      case (m_st)
        0: if (scr_en_i) ns = 1;
        1: if (!scr_en_i) ns = 0; else if (acc && com) ns = 2;
        default: if (acc) begin
          if (com) begin
            nl = 16'hFFFF;
            if (!scr_en_i) ns = 0;
          end else if (!skp) begin
            nl = r[15:0];
            if (!in_k_i && !in_ts_i) begin
              m_od = in_data_i ^ r[23:16];
              if (ncnt != 16'hFFFF) ncnt = ncnt + 16'd1;
            end
          end
        end
      endcase
      if (acc && com) ncnt = 0;
      if (acc) m_ov = 1; else if (out_ready_i) m_ov = 0;
      m_st = ns; m_l = nl; m_cnt = ncnt;
    end
    @(posedge clk_i); #1;
    n_chk++;
    if (out_valid_o !== m_ov) begin n_fail++; $display("FAIL out_valid: got %b want %b at %0t", out_valid_o, m_ov, $time); end
    if (m_ov) begin
      n_chk++;
      if (out_data_o !== m_od || out_k_o !== m_ok) begin
        n_fail++; $display("FAIL out_sym: got %h/%b want %h/%b at %0t", out_data_o, out_k_o, m_od, m_ok, $time);
      end
    end
    n_chk++;
    if (synced_o !== (m_st == 2)) begin n_fail++; $display("FAIL synced: got %b want %b at %0t", synced_o, m_st == 2, $time); end
    n_chk++;
    if (lfsr_o !== m_l) begin n_fail++; $display("FAIL lfsr: got %h want %h at %0t", lfsr_o, m_l, $time); end
    n_chk++;
    if (scr_cnt_o !== m_cnt) begin n_fail++; $display("FAIL scr_cnt: got %0d want %0d at %0t", scr_cnt_o, m_cnt, $time); end
    if (acc) outs.push_back(out_data_o);
  endtask

  task automatic send(input logic [7:0] d, input bit k, input bit ts);
    in_valid_i = 1'b1; in_data_i = d; in_k_i = k; in_ts_i = ts;
    tick();
  endtask

  task automatic idle();
    in_valid_i = 1'b0; in_k_i = 1'b0; in_ts_i = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst_i = 1'b1; tick(); tick(); rst_i = 1'b0;
    n_chk++;
    if (out_valid_o !== 1'b0 || lfsr_o !== 16'hFFFF || scr_cnt_o !== 16'h0 || out_data_o !== 8'h00 || synced_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_vals: got v=%b l=%h c=%h d=%h s=%b want 0/ffff/0/00/0",
                         out_valid_o, lfsr_o, scr_cnt_o, out_data_o, synced_o);
    end
  endtask

  task automatic test_lock_scramble();
    logic [7:0] exp[5] = '{8'hBC, 8'hFF, 8'h17, 8'hC0, 8'h14};
    outs.delete();
    scr_en_i = 1'b1; tick();
    send(8'hBC, 1, 0);
    n_chk++;
    if (synced_o !== 1'b1) begin n_fail++; $display("FAIL synced_at_com: got %b want 1", synced_o); end
    repeat (4) send(8'h00, 0, 0);
    idle();
    for (int i = 0; i < 5; i++) begin
      n_chk++;
      if (outs.size() <= i) begin n_fail++; $display("FAIL t1_out%0d: got none want %h", i, exp[i]); end
      else if (outs[i] !== exp[i]) begin n_fail++; $display("FAIL t1_out%0d: got %h want %h", i, outs[i], exp[i]); end
    end
    n_chk++;
    if (scr_cnt_o !== 16'd4) begin n_fail++; $display("FAIL t1_cnt: got %0d want 4", scr_cnt_o); end
  endtask

  task automatic test_skp_hold();
    logic [7:0] exp[5] = '{8'hBC, 8'hFF, 8'h1C, 8'h1C, 8'h17};
    logic [23:0] r;
    outs.delete();
    r = scr_byte(16'hFFFF);
    send(8'hBC, 1, 0); send(8'h00, 0, 0); send(8'h1C, 1, 0); send(8'h1C, 1, 0);
    n_chk++;
    if (lfsr_o !== r[15:0]) begin n_fail++; $display("FAIL t2_skp_lfsr: got %h want %h", lfsr_o, r[15:0]); end
    send(8'h00, 0, 0); idle();
    for (int i = 0; i < 5; i++) begin
      n_chk++;
      if (outs.size() <= i) begin n_fail++; $display("FAIL t2_out%0d: got none want %h", i, exp[i]); end
      else if (outs[i] !== exp[i]) begin n_fail++; $display("FAIL t2_out%0d: got %h want %h", i, outs[i], exp[i]); end
    end
  endtask

  task automatic test_ts_advance();
    outs.delete();
    send(8'hBC, 1, 0);
    repeat (15) send(8'h4A, 0, 1);
    send(8'h00, 0, 0); idle();
    n_chk++;
    if (outs.size() != 17) begin n_fail++; $display("FAIL t3_count: got %0d want 17", outs.size()); end
    else begin
      for (int i = 1; i <= 15; i++) begin
        n_chk++;
        if (outs[i] !== 8'h4A) begin n_fail++; $display("FAIL t3_ts%0d: got %h want 4a", i, outs[i]); end
      end
      n_chk++;
      if (outs[16] !== 8'h8D) begin n_fail++; $display("FAIL t3_data: got %h want 8d", outs[16]); end
    end
    n_chk++;
    if (scr_cnt_o !== 16'd1) begin n_fail++; $display("FAIL t3_cnt: got %0d want 1", scr_cnt_o); end
  endtask

  task automatic test_backpressure();
    logic [7:0] exp[4] = '{8'hBC, 8'hFF, 8'h17, 8'hC0};
    logic [23:0] r;
    outs.delete();
    r = scr_byte(16'hFFFF);
    send(8'hBC, 1, 0); send(8'h00, 0, 0);
    out_ready_i = 1'b0; in_valid_i = 1'b1; in_data_i = 8'h00; in_k_i = 1'b0; in_ts_i = 1'b0;
    repeat (3) begin
      tick();
      n_chk++;
      if (out_data_o !== 8'hFF || in_ready_o !== 1'b0 || lfsr_o !== r[15:0]) begin
        n_fail++; $display("FAIL t4_stall: got d=%h r=%b l=%h want ff/0/%h", out_data_o, in_ready_o, lfsr_o, r[15:0]);
      end
    end
    out_ready_i = 1'b1; tick();
    send(8'h00, 0, 0); idle();
    for (int i = 0; i < 4; i++) begin
      n_chk++;
      if (outs.size() <= i) begin n_fail++; $display("FAIL t4_out%0d: got none want %h", i, exp[i]); end
      else if (outs[i] !== exp[i]) begin n_fail++; $display("FAIL t4_out%0d: got %h want %h", i, outs[i], exp[i]); end
    end
  endtask

  task automatic test_enable_ctrl();
    logic [7:0] exp[6] = '{8'h55, 8'hBC, 8'hFF, 8'h17, 8'hBC, 8'h00};
    rst_i = 1'b1; tick(); rst_i = 1'b0;
    outs.delete();
    scr_en_i = 1'b1; tick();
    send(8'h55, 0, 0);
    n_chk++;
    if (synced_o !== 1'b0 || lfsr_o !== 16'hFFFF) begin
      n_fail++; $display("FAIL t5_hunt: got s=%b l=%h want 0/ffff", synced_o, lfsr_o);
    end
    send(8'hBC, 1, 0); send(8'h00, 0, 0);
    scr_en_i = 1'b0;
    send(8'h00, 0, 0);
    n_chk++;
    if (synced_o !== 1'b1) begin n_fail++; $display("FAIL t5_deferred: got %b want 1", synced_o); end
    send(8'hBC, 1, 0);
    n_chk++;
    if (synced_o !== 1'b0) begin n_fail++; $display("FAIL t5_off: got %b want 0", synced_o); end
    send(8'h00, 0, 0); idle();
    for (int i = 0; i < 6; i++) begin
      n_chk++;
      if (outs.size() <= i) begin n_fail++; $display("FAIL t5_out%0d: got none want %h", i, exp[i]); end
      else if (outs[i] !== exp[i]) begin n_fail++; $display("FAIL t5_out%0d: got %h want %h", i, outs[i], exp[i]); end
    end
  endtask

  task automatic test_mid_reset();
    scr_en_i = 1'b1; tick();
    send(8'hBC, 1, 0); send(8'h00, 0, 0); send(8'h00, 0, 0);
    out_ready_i = 1'b0; idle();
    rst_i = 1'b1; tick(); rst_i = 1'b0; out_ready_i = 1'b1;
    n_chk++;
    if (out_valid_o !== 1'b0 || lfsr_o !== 16'hFFFF || scr_cnt_o !== 16'h0 || synced_o !== 1'b0) begin
      n_fail++; $display("FAIL t6_reset: got v=%b l=%h c=%0d s=%b want 0/ffff/0/0", out_valid_o, lfsr_o, scr_cnt_o, synced_o);
    end
  endtask

  task automatic test_random();
    int sel;
    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(0, 39) == 0) scr_en_i = ~scr_en_i;
      in_valid_i  = ($urandom_range(0, 3) != 0);
      out_ready_i = ($urandom_range(0, 3) != 0);
      sel = $urandom_range(0, 9);
      in_ts_i = 1'b0;
      case (sel)
        0: begin in_k_i = 1'b1; in_data_i = 8'hBC; end
        1: begin in_k_i = 1'b1; in_data_i = 8'h1C; end
        2: begin in_k_i = 1'b1; in_data_i = 8'hF7; end
        3, 4: begin in_k_i = 1'b0; in_ts_i = 1'b1; in_data_i = 8'($urandom); end
        default: begin in_k_i = 1'b0; in_data_i = 8'($urandom); end
      endcase
      tick();
    end
    in_valid_i = 1'b0; out_ready_i = 1'b1;
  endtask

  initial begin
    test_reset();
    test_lock_scramble();
    test_skp_hold();
    test_ts_advance();
    test_backpressure();
    test_enable_ctrl();
    test_mid_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/pcie_scrambler_ctrl.md
Name: pcie_scrambler_ctrl

Overview:
Byte-wide sequencer for the PCIe Gen1/2 data scrambler, polynomial G(x)=x^16+x^5+x^4+x^3+1, seed FFFFh. It sits between the ordered-set/packet framer and the 8b/10b encoder and decides, per symbol, whether to reseed, hold, advance or apply the LFSR. It also enforces COM-based synchronisation and honours the scrambling-disable control from link training.

Parameters:
LFSR_SEED, 16'hFFFF, value loaded on reset and on every COM
CNT_W, 16, width of the scrambled-symbol counter

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
scr_en_i  in  1  scrambling enable from LTSSM / training control
in_valid_i  in  1  input symbol valid
in_ready_o  out  1  input ready
in_data_i  in  8  input symbol
in_k_i  in  1  symbol is a K-character
in_ts_i  in  1  symbol belongs to a TS1/TS2 ordered set (not scrambled)
out_valid_o  out  1  output valid
out_ready_i  in  1  downstream ready
out_data_o  out  8  output symbol
out_k_o  out  1  K flag, passed through
synced_o  out  1  state==LOCK
lfsr_o  out  16  current LFSR state (debug)
scr_cnt_o  out  CNT_W  saturating count of scrambled D symbols since the last COM

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_i is synchronous and active-high.
- Reset values: state OFF, LFSR=LFSR_SEED, out_valid_o=0, out_data_o=0, out_k_o=0, scr_cnt_o=0. in_ready_o is forced 0 while rst_i=1. A reset mid-stream drops any pending output.
- Handshake:
  - An input is accepted when in_valid_i && in_ready_o; in_ready_o = !out_valid_o || out_ready_i.
  - Output is registered with 1-cycle latency.
  - out_data_o and out_k_o stay stable while out_valid_o && !out_ready_i.
  - LFSR, state and counter update only on an accepted input.
- Bit step, one bit: keystream bit = L[15]. Then next L is {L[14:5], L[4]^L[15], L[3]^L[15], L[2]^L[15], L[1], L[0], L[15]}.
- Byte step: eight bit steps, LSB first. Keystream bit i XORs data bit i.
- Symbol classes: COM = K with data BCh; SKP = K with data 1Ch.
- States:
  - OFF: pass-through; LFSR held at seed.
    - Go to HUNT when scr_en_i=1, checked every cycle.
  - HUNT: pass-through; LFSR held at seed.
    - Go to OFF when scr_en_i=0.
    - An accepted COM goes to LOCK and loads the seed.
  - LOCK: rules per accepted symbol:
    - COM: passed unchanged; LFSR←seed with no advance; cnt←0.
      - If scr_en_i=0 at that COM, go to OFF.
      - Otherwise stay in LOCK.
    - SKP: unchanged; LFSR held.
    - Other K: unchanged; LFSR advances one byte.
    - D with in_ts_i=1: unchanged; LFSR advances one byte.
    - Other D: out = data ^ keystream byte; LFSR advances; cnt+1, saturating at all-ones.
    - A drop of scr_en_i in LOCK takes effect only at the next COM.
- K flag is always passed through. The COM that enters LOCK is itself output unscrambled.
- COM accepted in the same cycle as a scr_en_i change: the registered state before the edge selects the rule. From HUNT, the COM goes to LOCK only if scr_en_i=1.

Decomposition:
- Package pcie_scr_pkg holds: COM_SYM 8'hBC, SKP_SYM 8'h1C, LFSR_W 16, default seed, and the state enum {OFF, HUNT, LOCK}.
- One sub-module, pcie_lfsr_byte_step, is combinational. It takes the 16-bit state and returns the keystream byte plus the state after 8 steps.

Test Plan:
1. scr_en=1; COM(K,BCh), then D 00h ×4 → out BCh(K), FFh, 17h, C0h, 14h; synced_o=1 from the COM's output cycle; scr_cnt_o=4.
2. COM, D00h, SKP(K,1Ch) ×2, D00h → BCh, FFh, 1Ch, 1Ch, 17h; lfsr_o unchanged across both SKPs.
3. COM, 15× D4Ah with in_ts_i=1, then D00h → the 15 TS symbols emerge as 4Ah unchanged; the data byte emerges as 8Dh (16th keystream byte); scr_cnt_o=1.
4. Backpressure: in LOCK, hold in_valid=1, out_ready=0 for 3 cycles → out_data_o stable, in_ready_o=0, lfsr_o frozen; after release the keystream continues without gap or skip.
5. scr_en=1, no COM yet; D55h → out 55h, synced_o=0, lfsr_o=FFFFh. Then scr_en=0 in LOCK; D00h → still scrambled; next COM → OFF; following D00h → 00h.
6. Reset asserted with out_valid_o=1 mid-stream → next cycle out_valid_o=0, lfsr_o=FFFFh, state OFF, scr_cnt_o=0.
